dcache_direct_mapped: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache placed downstream of the CPU MEM stage.

---
 rtl/dcache_direct_mapped.sv | 152 +++++++++++++++
 tb/tb_dcache_direct_mapped.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_direct_mapped.sv
// Direct-mapped, write-back, write-allocate data cache between the CPU MEM stage and a
// line-wide backing memory. Hits are served combinationally; misses stall the CPU.
module dcache_direct_mapped #(
  parameter int INDEX_BITS = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic [31:0]  cpu_rdata_o,
  output logic         cpu_stall_o,
  output logic         mem_req_o,
  output logic         mem_we_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_wdata_o,
  input  logic [127:0] mem_rdata_i,
  input  logic         mem_ack_i
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 32 - INDEX_BITS - 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LINES-1:0]   dirty_q, dirty_d;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [127:0]       data_q [LINES];

  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_W-1:0]      tag_s;
  logic [1:0]            word_s;
  logic [127:0]          line_cur_s;
  logic [31:0]           word_cur_s;
  logic                  hit_s;
  logic                  line_we_s;
  logic [127:0]          line_wdata_s;
  logic                  unused_s;

  function automatic logic [127:0] merge_word(input logic [127:0] line,
                                              input logic [1:0]   sel,
                                              input logic [31:0]  w);
    logic [127:0] r;
    case (sel)
      2'd0:    r = {line[127:32], w};
      2'd1:    r = {line[127:64], w, line[31:0]};
      2'd2:    r = {line[127:96], w, line[63:0]};
      default: r = {w, line[95:0]};
    endcase
    return r;
  endfunction

  assign idx_s      = cpu_addr_i[INDEX_BITS+3:4];
  assign tag_s      = cpu_addr_i[31:INDEX_BITS+4];
  assign word_s     = cpu_addr_i[3:2];
  assign unused_s   = ^cpu_addr_i[1:0];
  assign line_cur_s = data_q[idx_s];
  assign word_cur_s = line_cur_s[{word_s, 5'd0} +: 32];
  assign hit_s      = (state_q == ST_IDLE) && valid_q[idx_s] && (tag_q[idx_s] == tag_s);
  assign cpu_stall_o = (state_q != ST_IDLE) || (cpu_req_i && !hit_s);

  // Next-state, line update and output decode
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    line_we_s    = 1'b0;
    line_wdata_s = merge_word(line_cur_s, word_s, cpu_wdata_i);
    cpu_rdata_o  = 32'd0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = 32'd0;
    mem_wdata_o  = 128'd0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i && hit_s) begin
          if (cpu_we_i) begin
            line_we_s      = 1'b1;
            dirty_d[idx_s] = 1'b1;
          end else begin
            cpu_rdata_o = word_cur_s;
          end
        end else if (cpu_req_i) begin
          // never refill over a dirty line: write it back first
          if (valid_q[idx_s] && dirty_q[idx_s]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_ALLOCATE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[idx_s], idx_s, 4'd0};
        mem_wdata_o = line_cur_s;
        if (mem_ack_i) begin
          state_d = ST_ALLOCATE;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_ALLOCATE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = {tag_s, idx_s, 4'd0};
        if (mem_ack_i) begin
          line_we_s      = 1'b1;
          line_wdata_s   = mem_rdata_i;
          valid_d[idx_s] = 1'b1;
          dirty_d[idx_s] = 1'b0;
          state_d        = ST_IDLE;
        end else begin
          state_d = ST_ALLOCATE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state; reset drops any in-flight transaction and discards dirty lines
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data arrays carry no reset; valid qualifies them
  always_ff @(posedge clk_i) begin
    if (line_we_s) begin
      data_q[idx_s] <= line_wdata_s;
      tag_q[idx_s]  <= tag_s;
    end
  end

endmodule

// File: tb/tb_dcache_direct_mapped.sv
// Scoreboard bench for dcache_direct_mapped: stimulus pushes expected CPU responses and memory
// transactions into queues; a monitor pops and compares whenever the DUT presents them.
module tb_dcache_direct_mapped;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         cpu_req_i = 1'b0;
  logic         cpu_we_i = 1'b0;
  logic [31:0]  cpu_addr_i = 32'd0;
  logic [31:0]  cpu_wdata_i = 32'd0;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic [127:0] mem_rdata_i = 128'd0;
  logic         mem_ack_i;
  logic         resp_ack = 1'b0;
  logic         spur_ack = 1'b0;

  assign mem_ack_i = resp_ack | spur_ack;

  dcache_direct_mapped #(.INDEX_BITS(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic we; logic [31:0] addr; logic [127:0] wdata; } mem_exp_t;
  typedef struct { logic [31:0] rdata; int stall; } cpu_exp_t;

  mem_exp_t     mem_q[$];
  cpu_exp_t     cpu_q[$];
  logic [127:0] bmem [logic [31:0]];
  int           n_tests = 0;
  int           n_fail = 0;
  int           ack_dly = 0;

  function automatic logic [127:0] dflt_line(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [127:0] wd);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.wdata = wd;
    mem_q.push_back(m);
  endtask

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input int exp_stall);
    cpu_exp_t ce;
    logic done;
    ce.rdata = exp_rd; ce.stall = exp_stall;
    cpu_q.push_back(ce);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) done = 1'b1;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL access_timeout: addr=%h still stalled after 60 cycles, required completion", addr);
    end
    @(posedge clk_i); #1;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'd0; cpu_wdata_i = 32'd0;
  endtask

  // Backing memory: acks after ack_dly cycles, abandons the wait if the request disappears
  initial begin
    forever begin
      @(posedge clk_i); #2;
      while (mem_req_o) begin
        for (int k = 0; k < ack_dly; k++) begin
          @(posedge clk_i); #2;
          if (!mem_req_o) break;
        end
        if (mem_req_o) begin
          if (mem_we_o) begin
            bmem[mem_addr_o] = mem_wdata_o;
          end else if (bmem.exists(mem_addr_o)) begin
            mem_rdata_i = bmem[mem_addr_o];
          end else begin
            mem_rdata_i = dflt_line(mem_addr_o);
          end
          resp_ack = 1'b1;
          @(posedge clk_i); #2;
          resp_ack = 1'b0;
          mem_rdata_i = 128'd0;
        end
      end
    end
  end

  // Monitor: CPU completions, idle outputs, memory transactions and their stability
  initial begin
    cpu_exp_t ce;
    mem_exp_t me;
    mem_exp_t cur;
    logic req_prev, ack_prev;
    int stall_cnt;
    req_prev = 1'b0; ack_prev = 1'b0; stall_cnt = 0;
    cur.we = 1'b0; cur.addr = 32'd0; cur.wdata = 128'd0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        stall_cnt = 0; req_prev = 1'b0; ack_prev = 1'b0;
      end else begin
        if (cpu_req_i && cpu_stall_o) begin
          stall_cnt++;
        end else if (cpu_req_i) begin
          n_tests++;
          if (cpu_q.size() == 0) begin
            n_fail++;
            $display("FAIL cpu_unexpected: addr=%h rdata=%h, no response required", cpu_addr_i, cpu_rdata_o);
          end else begin
            ce = cpu_q.pop_front();
            if (cpu_rdata_o !== ce.rdata || stall_cnt != ce.stall) begin
              n_fail++;
              $display("FAIL cpu_resp: addr=%h rdata=%h stall_cycles=%0d, required rdata=%h stall_cycles=%0d",
                       cpu_addr_i, cpu_rdata_o, stall_cnt, ce.rdata, ce.stall);
            end
          end
          stall_cnt = 0;
        end else begin
          n_tests++;
          if (cpu_stall_o !== 1'b0 || mem_req_o !== 1'b0 || mem_we_o !== 1'b0 ||
              cpu_rdata_o !== 32'd0 || mem_addr_o !== 32'd0 || mem_wdata_o !== 128'd0) begin
            n_fail++;
            $display("FAIL idle_outputs: stall=%b req=%b we=%b rdata=%h addr=%h, required all zero",
                     cpu_stall_o, mem_req_o, mem_we_o, cpu_rdata_o, mem_addr_o);
          end
        end
        if (mem_req_o && (!req_prev || ack_prev)) begin
          n_tests++;
          if (mem_q.size() == 0) begin
            n_fail++;
            $display("FAIL mem_unexpected: we=%b addr=%h, no transaction required", mem_we_o, mem_addr_o);
          end else begin
            me = mem_q.pop_front();
            if (mem_we_o !== me.we || mem_addr_o !== me.addr || (me.we && mem_wdata_o !== me.wdata)) begin
              n_fail++;
              $display("FAIL mem_txn: we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                       mem_we_o, mem_addr_o, mem_wdata_o, me.we, me.addr, me.wdata);
            end
          end
          cur.we = mem_we_o; cur.addr = mem_addr_o; cur.wdata = mem_wdata_o;
        end else if (mem_req_o) begin
          n_tests++;
          if (mem_we_o !== cur.we || mem_addr_o !== cur.addr || mem_wdata_o !== cur.wdata) begin
            n_fail++;
            $display("FAIL mem_stable: we=%b addr=%h, required held we=%b addr=%h",
                     mem_we_o, mem_addr_o, cur.we, cur.addr);
          end
        end
        req_prev = mem_req_o;
        ack_prev = mem_ack_i;
      end
    end
  end

  // Reset must drop the memory request without waiting for a clock edge
  initial begin
    forever begin
      @(negedge rst_i); #1;
      n_tests++;
      if (mem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_req: mem_req_o=%b during reset, required 0", mem_req_o);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, prev, dv;
    logic        seen;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b1;

    // Cold read
    bmem[32'h40] = 128'h00004444_00003333_00002222_00001111;
    ack_dly = 3;
    push_mem(1'b0, 32'h40, 128'd0);
    access(1'b0, 32'h40, 32'd0, 32'h1111, 5);

    // Write hit then read hits
    access(1'b1, 32'h44, 32'h12345678, 32'd0, 0);
    access(1'b0, 32'h44, 32'd0, 32'h12345678, 0);
    access(1'b0, 32'h4C, 32'd0, 32'h4444, 0);

    // Dirty conflict: writeback then allocate
    ack_dly = 2;
    push_mem(1'b1, 32'h40, 128'h00004444_00003333_12345678_00001111);
    push_mem(1'b0, 32'h240, 128'd0);
    access(1'b0, 32'h240, 32'd0, 32'h240, 7);

    // Clean conflict: allocate only; then the written-back data returns
    ack_dly = 1;
    push_mem(1'b0, 32'h440, 128'd0);
    access(1'b0, 32'h440, 32'd0, 32'h440, 3);
    ack_dly = 0;
    push_mem(1'b0, 32'h40, 128'd0);
    access(1'b0, 32'h44, 32'd0, 32'h12345678, 2);

    // Ack delays 0..7 on a chain of dirty conflicts, with a spurious ack in between
    prev = 32'd0;
    for (int d = 0; d < 8; d++) begin
      dv = 32'(d);
      a = 32'h100 + dv * 32'h200;
      ack_dly = d;
      if (d == 0) begin
        push_mem(1'b0, a, 128'd0);
        access(1'b1, a + 32'd8, 32'hA000_0000 | dv, 32'd0, 2);
      end else begin
        push_mem(1'b1, prev, {prev + 32'd12, 32'hA000_0000 | (dv - 32'd1), prev + 32'd4, prev});
        push_mem(1'b0, a, 128'd0);
        access(1'b1, a + 32'd8, 32'hA000_0000 | dv, 32'd0, 2 * d + 3);
      end
      @(posedge clk_i); #1 spur_ack = 1'b1;
      @(posedge clk_i); #1 spur_ack = 1'b0;
      access(1'b0, a + 32'd8, 32'd0, 32'hA000_0000 | dv, 0);
      prev = a;
    end

    // Reset in the middle of an allocate
    ack_dly = 20;
    push_mem(1'b0, 32'h80, 128'd0);
    @(posedge clk_i); #1;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h80;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      if (mem_req_o) seen = 1'b1;
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL alloc_timeout: mem_req_o=%b, required 1 within 10 cycles", mem_req_o);
    end
    @(posedge clk_i); #3;
    rst_i = 1'b0; cpu_req_i = 1'b0; cpu_addr_i = 32'd0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    // Dirty line was discarded: no writeback, old memory contents come back
    ack_dly = 1;
    push_mem(1'b0, 32'hF00, 128'd0);
    access(1'b0, 32'hF08, 32'd0, 32'hF08, 3);
    push_mem(1'b0, 32'h240, 128'd0);
    access(1'b0, 32'h240, 32'd0, 32'h240, 3);

    repeat (3) @(posedge clk_i);
    n_tests++;
    if (cpu_q.size() != 0) begin
      n_fail++;
      $display("FAIL cpu_queue: %0d responses outstanding, required 0", cpu_q.size());
    end
    n_tests++;
    if (mem_q.size() != 0) begin
      n_fail++;
      $display("FAIL mem_queue: %0d transactions outstanding, required 0", mem_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
